gf2m_inv: RTL and testbench

GF2M_INV -- requirements
Module: gf2m_inv

---
 rtl/gf2m_inv.sv | 134 +++++++++++++
 tb/tb_gf2m_inv.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/gf2m_inv.sv
// Constant-time GF(2^M) inverter/divider using Brunner's extended-Euclid step,
// one step per clock for exactly 2M clocks, with a valid/ready handshake on both sides.
module gf2m_inv #(
  parameter int         M    = 5,
  parameter logic [M:0] POLY = 6'b100101
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         IN_VALID,
  output logic         IN_READY,
  input  logic         OP,
  input  logic [M-1:0] A,
  input  logic [M-1:0] B,
  output logic [M-1:0] OUT,
  output logic         OUT_VALID,
  input  logic         OUT_READY,
  output logic         ERR
);
  localparam int CW = $clog2(2*M+1);
  localparam int DW = CW + 1;

  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

  state_t        r_state;
  logic [M:0]    r_s, r_r;
  logic [M-1:0]  r_u, r_v;
  logic [DW-1:0] r_delta;
  logic [CW-1:0] r_cnt;
  logic          r_err;
  logic [M-1:0]  r_out;
  logic          r_in_ready, r_out_valid;

  logic [M:0]    w_s, w_r, w_sh;
  logic [M-1:0]  w_u, w_v, w_vx;
  logic [DW-1:0] w_delta;

  function automatic logic [M-1:0] mulx(input logic [M-1:0] u);
    return u[M-1] ? ({u[M-2:0], 1'b0} ^ POLY[M-1:0]) : {u[M-2:0], 1'b0};
  endfunction

  // Odd u: adding POLY clears bit 0, so the shift is exact.
  function automatic logic [M-1:0] divx(input logic [M-1:0] u);
    return u[0] ? ({1'b0, u[M-1:1]} ^ POLY[M:1]) : {1'b0, u[M-1:1]};
  endfunction

  assign w_sh = (r_s[M] ? (r_s ^ r_r) : r_s) << 1;
  assign w_vx = r_s[M] ? (r_v ^ r_u) : r_v;

  always_comb begin
    w_s     = r_s;
    w_r     = r_r;
    w_u     = r_u;
    w_v     = r_v;
    w_delta = r_delta;
    if (!r_r[M]) begin
      w_r     = {r_r[M-1:0], 1'b0};
      w_u     = mulx(r_u);
      w_delta = r_delta + DW'(1);
    end else if (r_delta == '0) begin
      w_r     = w_sh;
      w_s     = r_r;
      w_u     = mulx(w_vx);
      w_v     = r_u;
      w_delta = DW'(1);
    end else begin
      w_s     = w_sh;
      w_v     = w_vx;
      w_u     = divx(r_u);
      w_delta = r_delta - DW'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= IDLE;
      r_s         <= '0;
      r_r         <= '0;
      r_u         <= '0;
      r_v         <= '0;
      r_delta     <= '0;
      r_cnt       <= '0;
      r_err       <= 1'b0;
      r_out       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (IN_VALID) begin
            r_s        <= POLY;
            r_r        <= {1'b0, A};
            r_u        <= OP ? B : M'(1);
            r_v        <= '0;
            r_delta    <= '0;
            r_cnt      <= '0;
            r_err      <= (A == '0);
            r_in_ready <= 1'b0;
            r_state    <= ITER;
          end
        end
        ITER: begin
          r_s     <= w_s;
          r_r     <= w_r;
          r_u     <= w_u;
          r_v     <= w_v;
          r_delta <= w_delta;
          r_cnt   <= r_cnt + CW'(1);
          if (r_cnt == CW'(2*M-1)) begin
            r_out       <= r_err ? '0 : w_u;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: begin
          if (OUT_READY) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign IN_READY  = r_in_ready;
  assign OUT_VALID = r_out_valid;
  assign OUT       = r_out;
  assign ERR       = r_out_valid & r_err;
endmodule

// File: tb/tb_gf2m_inv.sv
// Bench for gf2m_inv: fixed vectors, exhaustive M=5 inverses, random ops against a
// field-arithmetic model, plus handshake, throughput and reset-abort sequences.
module tb_gf2m_inv;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       iv5 = 1'b0, opi5 = 1'b0, ordy5 = 1'b0;
  logic       ir5, ov5, err5;
  logic [4:0] a5 = '0, b5 = '0, out5;
  logic       iv8 = 1'b0, opi8 = 1'b0, ordy8 = 1'b0;
  logic       ir8, ov8, err8;
  logic [7:0] a8 = '0, b8 = '0, out8;

  gf2m_inv #(.M(5), .POLY(6'b100101)) dut5 (
    .CLK(clk), .RST(rst), .IN_VALID(iv5), .IN_READY(ir5), .OP(opi5), .A(a5), .B(b5),
    .OUT(out5), .OUT_VALID(ov5), .OUT_READY(ordy5), .ERR(err5));

  gf2m_inv #(.M(8), .POLY(9'h11B)) dut8 (
    .CLK(clk), .RST(rst), .IN_VALID(iv8), .IN_READY(ir8), .OP(opi8), .A(a8), .B(b8),
    .OUT(out8), .OUT_VALID(ov8), .OUT_READY(ordy8), .ERR(err8));

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    bit op;
    int a;
    int b;
    int exp_out;
    bit exp_err;
  } vec_t;

  function automatic vec_t mkv(bit op, int a, int b, int eo, bit ee);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.exp_out = eo; v.exp_err = ee;
    return v;
  endfunction

  // Polynomial-basis product reduced modulo poly (shift-and-add).
  function automatic int gf_mul(int a, int b, int m, int poly);
    int p = 0;
    int aa = a;
    for (int i = 0; i < m; i++) begin
      if (((b >> i) & 1) != 0) p = p ^ aa;
      aa = aa << 1;
      if (((aa >> m) & 1) != 0) aa = aa ^ poly;
    end
    return p;
  endfunction

  function automatic int gf_inv(int a, int m, int poly);
    for (int y = 1; y < (1 << m); y++)
      if (gf_mul(a, y, m, poly) == 1) return y;
    return 0;
  endfunction

  function automatic int gf_div(bit op, int a, int b, int m, int poly);
    if (a == 0) return 0;
    return gf_mul(op ? b : 1, gf_inv(a, m, poly), m, poly);
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic run5(input bit op, input int a, input int b,
                      output int o, output int e, output int lat);
    int n = 0;
    @(negedge clk);
    while (!ir5 && n < 100) begin @(negedge clk); n++; end
    chk("m5_in_ready_before_accept", int'(ir5), 1);
    iv5 = 1'b1; opi5 = op; a5 = 5'(a); b5 = 5'(b);
    @(negedge clk);
    iv5 = 1'b0; a5 = 5'($urandom); b5 = 5'($urandom); opi5 = 1'($urandom);
    lat = 0;
    while (!ov5 && lat < 100) begin @(negedge clk); lat++; end
    o = int'(out5); e = int'(err5);
    ordy5 = 1'b1;
    @(negedge clk);
    ordy5 = 1'b0;
  endtask

  task automatic run8(input bit op, input int a, input int b,
                      output int o, output int e, output int lat);
    int n = 0;
    @(negedge clk);
    while (!ir8 && n < 100) begin @(negedge clk); n++; end
    iv8 = 1'b1; opi8 = op; a8 = 8'(a); b8 = 8'(b);
    @(negedge clk);
    iv8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
    lat = 0;
    while (!ov8 && lat < 100) begin @(negedge clk); lat++; end
    o = int'(out8); e = int'(err8);
    ordy8 = 1'b1;
    @(negedge clk);
    ordy8 = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[$];
    int   o, e, lat, n, seen;
    int   q[$];

    vecs.push_back(mkv(1'b0, 'b00010, 0,       'b10010, 1'b0));
    vecs.push_back(mkv(1'b1, 'b00010, 'b00011, 'b10011, 1'b0));
    vecs.push_back(mkv(1'b0, 'b00001, 0,       'b00001, 1'b0));
    vecs.push_back(mkv(1'b0, 0,       0,       0,       1'b1));
    vecs.push_back(mkv(1'b1, 0,       'b00111, 0,       1'b1));

    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", int'(ir5), 1);
    chk("rst_out_valid", int'(ov5), 0);
    chk("rst_out", int'(out5), 0);
    chk("rst_err", int'(err5), 0);
    chk("rst_in_ready_m8", int'(ir8), 1);
    rst = 1'b0;

    foreach (vecs[i]) begin
      run5(vecs[i].op, vecs[i].a, vecs[i].b, o, e, lat);
      chk($sformatf("vec%0d_out", i), o, vecs[i].exp_out);
      chk($sformatf("vec%0d_err", i), e, int'(vecs[i].exp_err));
      chk($sformatf("vec%0d_latency", i), lat, 10);
    end

    for (int a = 1; a < 32; a++) begin
      run5(1'b0, a, 0, o, e, lat);
      chk($sformatf("inv_product_a%0d", a), gf_mul(o, a, 5, 'h25), 1);
      chk($sformatf("inv_latency_a%0d", a), lat, 10);
    end

    for (int i = 0; i < 40; i++) begin
      bit rop;
      int ra, rb;
      rop = 1'($urandom);
      ra  = (i % 10 == 0) ? 0 : int'($urandom_range(31, 0));
      rb  = int'($urandom_range(31, 0));
      run5(rop, ra, rb, o, e, lat);
      chk($sformatf("rand5_%0d_out op=%0d a=%0h b=%0h", i, rop, ra, rb), o, gf_div(rop, ra, rb, 5, 'h25));
      chk($sformatf("rand5_%0d_err", i), e, (ra == 0) ? 1 : 0);
    end

    run8(1'b0, 'h53, 0, o, e, lat);
    chk("m8_inv53_out", o, 'hCA);
    chk("m8_inv53_err", e, 0);
    chk("m8_inv53_latency", lat, 16);
    for (int i = 0; i < 10; i++) begin
      bit rop;
      int ra, rb;
      rop = 1'($urandom);
      ra  = int'($urandom_range(255, 1));
      rb  = int'($urandom_range(255, 0));
      run8(rop, ra, rb, o, e, lat);
      chk($sformatf("rand8_%0d_out op=%0d a=%0h b=%0h", i, rop, ra, rb), o, gf_div(rop, ra, rb, 8, 'h11B));
      chk($sformatf("rand8_%0d_latency", i), lat, 16);
    end

    // Back-to-back operations with both handshakes held high.
    @(negedge clk);
    n = 0;
    while (!ir5 && n < 100) begin @(negedge clk); n++; end
    iv5 = 1'b1; opi5 = 1'b0; a5 = 5'd3; ordy5 = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (ov5) begin
        q.push_back(c);
        chk($sformatf("tput_out_c%0d", c), int'(out5), gf_inv(3, 5, 'h25));
      end
    end
    iv5 = 1'b0;
    n = 0;
    while (!ir5 && n < 100) begin @(negedge clk); n++; end
    ordy5 = 1'b0;
    chk("tput_results_seen", q.size(), 2);
    if (q.size() >= 2) chk("tput_interval", q[1] - q[0], 12);

    // Zero operand, result held back by the consumer while requests keep arriving.
    @(negedge clk);
    iv5 = 1'b1; opi5 = 1'b0; a5 = 5'd0;
    @(negedge clk);
    iv5 = 1'b0;
    lat = 0;
    while (!ov5 && lat < 100) begin @(negedge clk); lat++; end
    chk("zero_latency", lat, 10);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("zero_hold%0d_out", k), int'(out5), 0);
      chk($sformatf("zero_hold%0d_err", k), int'(err5), 1);
      chk($sformatf("zero_hold%0d_flags", k), int'({ir5, ov5}), 'b01);
      iv5 = (k % 2 == 0); a5 = 5'($urandom_range(31, 1)); opi5 = 1'($urandom);
      @(negedge clk);
    end
    chk("zero_hold_final_out", int'(out5), 0);
    chk("zero_hold_final_valid", int'(ov5), 1);
    iv5 = 1'b0; ordy5 = 1'b1;
    @(negedge clk);
    ordy5 = 1'b0;
    chk("zero_release_in_ready", int'(ir5), 1);
    chk("zero_release_out_valid", int'(ov5), 0);

    // Reset lands on the edge that would perform the third step.
    iv5 = 1'b1; opi5 = 1'b0; a5 = 5'd7;
    @(negedge clk);
    iv5 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_in_ready", int'(ir5), 1);
    chk("abort_out_valid", int'(ov5), 0);
    seen = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (ov5) seen++;
    end
    chk("abort_no_result", seen, 0);
    run5(1'b1, 7, 9, o, e, lat);
    chk("after_abort_out", o, gf_div(1'b1, 7, 9, 5, 'h25));
    chk("after_abort_latency", lat, 10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
